// File: rtl/hd_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hd_sched_pkg
// Description : Shared types, constants and the round-robin pick function
//               for the hd_kernel_sched block.
// Revision    : 1.0 - initial release
// ============================================================================
package hd_sched_pkg;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Smallest legal evaluation window (cycles k_x is held before sampling)
    localparam int C_KLAT_MIN = 1;

    // The pick function works on the widest supported requester vector;
    // callers zero-extend their narrower vectors.
    localparam int C_MAX_REQ = 16;
    localparam int C_MAX_IDW = 4;

    typedef struct packed {
        logic                 found;
        logic [C_MAX_IDW-1:0] idx;
        logic [C_MAX_REQ-1:0] onehot;
    } rr_pick_t;

    // First asserted bit of valid at or after ptr, wrapping at nreq.
    function automatic rr_pick_t rr_pick(
        input logic [C_MAX_REQ-1:0] valid,
        input logic [C_MAX_IDW-1:0] ptr,
        input int                   nreq
    );
        rr_pick_t             res;
        int                   cand;
        logic [C_MAX_IDW-1:0] sel;
        res = '0;
        for (int k = 0; k < C_MAX_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= nreq) begin
                cand = cand - nreq;
            end
            sel = cand[C_MAX_IDW-1:0];
            if ((k < nreq) && !res.found && valid[sel]) begin
                res.found       = 1'b1;
                res.idx         = sel;
                res.onehot[sel] = 1'b1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hd_kernel_sched_arb.sv
`default_nettype none
// ============================================================================
// Module      : hd_rr_arbiter
// Description : Combinational round-robin pick over NREQ requesters with a
//               registered search pointer advanced past each winner.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               valid          - per-requester request
//               enable         - an accept opportunity exists this cycle
//               grant          - one-hot grant (zero when not enabled)
//               grant_idx      - index of the winner
//               grant_any      - a grant is issued this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module hd_rr_arbiter
    import hd_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       w_ptr_next;
    logic [C_MAX_REQ-1:0] w_valid_pad;
    logic [C_MAX_IDW-1:0] w_ptr_pad;
    rr_pick_t             w_pick;
    logic                 w_unused_pick;

    assign w_valid_pad = C_MAX_REQ'(valid);
    assign w_ptr_pad   = C_MAX_IDW'(r_ptr);
    assign w_pick      = rr_pick(w_valid_pad, w_ptr_pad, NREQ);

    // Upper pick bits are always zero for NREQ below the package maximum.
    assign w_unused_pick = ^w_pick;

    assign grant_any = enable & w_pick.found;
    assign grant     = grant_any ? w_pick.onehot[NREQ-1:0] : '0;
    assign grant_idx = w_pick.idx[IDW-1:0];

    // Explicit wrap: NREQ need not be a power of two.
    assign w_ptr_next = (w_pick.idx == C_MAX_IDW'(NREQ - 1)) ? '0
                      : w_pick.idx[IDW-1:0] + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (grant_any) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hd_kernel_sched.sv
`default_nettype none
// ============================================================================
// Module      : hd_kernel_sched
// Description : Round-robin scheduler sharing one combinational kernel among
//               NREQ requesters. Accepts one operand, holds it on k_x for
//               KLAT cycles, samples k_y and returns it tagged with the
//               requester index.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               req_valid/req_data    - requester operands (i at [i*W +: W])
//               req_ready             - one-hot accept
//               k_x / k_y             - kernel operand out / result in
//               rsp_valid/rsp_data/rsp_id/rsp_ready - response handshake
//               busy                  - scheduler not idle
// Revision    : 1.0 - initial release
// ============================================================================
module hd_kernel_sched
    import hd_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int KLAT = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      k_x,
    input  logic [W-1:0]      k_y,
    output logic              rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready,
    output logic              busy
);

    localparam int C_CW = (KLAT > 1) ? $clog2(KLAT) : 1;

    generate
        if (KLAT < C_KLAT_MIN) begin : g_klat_check
            $error("hd_kernel_sched: KLAT must be at least 1");
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_next;
    logic [C_CW-1:0] r_cnt;
    logic [IDW-1:0]  r_id;
    logic            w_cnt_zero;
    logic            w_accept_opp;
    logic            w_take;
    logic [IDW-1:0]  w_grant_idx;

    assign w_cnt_zero = (r_cnt == '0);

    // Reset blocks any grant so no operand is consumed in a reset cycle.
    assign w_accept_opp = !rst && ((r_state == ST_IDLE) ||
                                   ((r_state == ST_HOLD) && rsp_ready));

    hd_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_valid),
        .enable    (w_accept_opp),
        .grant     (req_ready),
        .grant_idx (w_grant_idx),
        .grant_any (w_take)
    );

    assign busy = (r_state != ST_IDLE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_take)     w_state_next = ST_EVAL;
            ST_EVAL: if (w_cnt_zero) w_state_next = ST_HOLD;
            ST_HOLD: if (rsp_ready)  w_state_next = w_take ? ST_EVAL : ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_id      <= '0;
            k_x       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            r_state <= w_state_next;

            // k_x only moves on accept, so the kernel sees a stable operand
            // for the whole EVAL window and while the result waits in HOLD.
            if (w_take) begin
                k_x   <= req_data[int'(w_grant_idx)*W +: W];
                r_id  <= w_grant_idx;
                r_cnt <= C_CW'(KLAT - 1);
            end else if ((r_state == ST_EVAL) && !w_cnt_zero) begin
                r_cnt <= r_cnt - C_CW'(1);
            end

            if ((r_state == ST_EVAL) && w_cnt_zero) begin
                rsp_valid <= 1'b1;
                rsp_data  <= k_y;
                rsp_id    <= r_id;
            end else if ((r_state == ST_HOLD) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/hd_kernel_sched.md
# hd_kernel_sched

Round-robin scheduler sharing one combinational benchmark kernel (32-bit operand in, 32-bit result out, instantiated outside this block) among NREQ requesters. Accepts one operand at a time from a valid/ready requester port, holds it stable on the kernel input for a fixed evaluation window, samples the kernel result, and returns it with the requester ID on a valid/ready response port. Sits between the host-side request fabric and a single shared benchmark circuit instance.

## Interface
- NREQ, 4: number of requesters, 2..16
- W, 32: operand/result width
- KLAT, 2: evaluation cycles the kernel input is held before sampling k_y, ≥1
- IDW, $clog2(NREQ): response ID width (derived)
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_data  in  NREQ*W  operands, requester i at bits [i*W +: W]
- req_ready  out  NREQ  one-hot grant/accept, at most one bit high
- k_x  out  W  registered operand driven to kernel
- k_y  in  W  kernel result, combinational function of k_x
- rsp_valid  out  1  result valid
- rsp_data  out  W  sampled kernel result
- rsp_id  out  IDW  index of requester that issued the operand
- rsp_ready  in  1  response consumer accept
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EVAL, HOLD.
- Accept opportunity: state IDLE, or state HOLD with rsp_ready=1.
- On an accept opportunity with any req_valid high: round-robin pick winner w, searching from ptr upward with wrap; req_ready[w]=1 combinationally in that cycle; transfer occurs (req_valid[w]&req_ready[w]). Registers: k_x←req_data[w], id←w, ptr←(w+1) mod NREQ, cnt←KLAT-1, state←EVAL.
- IDLE, no valid: stay IDLE, req_ready all 0.
- EVAL: cnt decrements each cycle; when cnt==0: rsp_data←k_y, rsp_id←id, rsp_valid←1, state←HOLD.
- HOLD: rsp_valid held high, rsp_data/rsp_id stable until rsp_ready. With rsp_ready=1: rsp_valid←0 and, if any req_valid, new accept in same cycle (→EVAL), else →IDLE.
- k_x changes only on accept; stable through EVAL and HOLD.
- req_ready is 0 in EVAL and in HOLD while rsp_ready=0; non-winning requesters see req_ready 0.
- Requester deasserting req_valid before grant is legal; no grant is issued to it.

## Timing
- Reset values: state IDLE, ptr 0, cnt 0, k_x 0, rsp_valid 0, rsp_data 0, rsp_id 0, req_ready 0, busy 0.
- Accept in cycle t → k_x valid at t+1 → rsp_valid first high at t+KLAT+1.
- Back-to-back throughput, rsp_ready tied high: one result per KLAT+1 cycles.
- Simultaneous requests: winner is first valid index at or after ptr; after grant to NREQ-1 search restarts at 0.
- Reset asserted mid-EVAL or mid-HOLD: operation dropped, no response emitted, all outputs to reset values next cycle; ptr returns to 0.
- rst has priority over every transfer in the same cycle.

## Structure
- Package hd_sched_pkg: state enum (IDLE/EVAL/HOLD), KLAT lower-bound check constant, rr_pick function (valid vector, ptr → one-hot and index).
- Sub-module hd_rr_arbiter: combinational round-robin pick plus registered ptr update on grant; scheduler owns FSM, cnt, datapath registers.
- Kernel not instantiated here; the wrapper connects k_x/k_y to the benchmark netlist.

## Test plan
- Single request, NREQ=4, KLAT=2, bench kernel k_y=~k_x: req_valid=4'b0100, data 0x0000_00FF → req_ready=4'b0100 same cycle; rsp_valid at t+3 with rsp_data 0xFFFF_FF00, rsp_id 2; busy high t+1..t+3.
- All four valid continuously, rsp_ready=1: grant order 0,1,2,3,0; responses every 3 cycles; rsp_id sequence 0,1,2,3,0.
- Backpressure: rsp_ready=0 for 5 cycles in HOLD → rsp_valid, rsp_data, rsp_id, k_x stable; req_ready all 0; on rsp_ready=1 with req_valid[1]=1 → req_ready=4'b0010 in that same cycle, rsp_valid falls next cycle.
- Wrap-around: after grant to requester 3, req_valid=4'b1001 → next grant to 0, then 3.
- Reset mid-EVAL (one cycle after accept): rst=1 → next cycle state IDLE, k_x 0, rsp_valid never asserts; next request with req_valid=4'b1111 grants requester 0.
- KLAT=1 variant: accept at t → rsp_valid at t+2; sustained throughput one result per 2 cycles.
